// File: rtl/ebpc_pkg.sv
// Shared EBPC definitions: element width, default beat packing and unpacker state encoding.
package ebpc_pkg;

    localparam int unsigned DATA_W                 = 8;
    localparam int unsigned WORDS_PER_BEAT_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        RUN
    } unpacker_state_t;

endpackage

// File: rtl/ebpc_input_unpacker.sv
// Serialises wide packed input beats into one DATA_W element per cycle for the EBPC encoder,
// flagging the last element of a programmed-length stream.
module ebpc_input_unpacker
    import ebpc_pkg::*;
#(
    parameter int unsigned WORDS_PER_BEAT = WORDS_PER_BEAT_DEFAULT,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [CNT_W-1:0]                 num_elems_i,
    input  logic [DATA_W*WORDS_PER_BEAT-1:0] beat_data_i,
    input  logic                             beat_vld_i,
    output logic                             beat_rdy_o,
    output logic [DATA_W-1:0]                data_o,
    output logic                             last_o,
    output logic                             vld_o,
    input  logic                             rdy_i,
    output logic                             idle_o,
    output logic                             done_o,
    output logic                             err_o
);

    localparam int unsigned              LANE_W    = $clog2(WORDS_PER_BEAT);
    localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(WORDS_PER_BEAT - 1);

    unpacker_state_t                          state_q, state_d;
    logic [WORDS_PER_BEAT-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic                                     buf_full_q, buf_full_d;
    logic [LANE_W-1:0]                        lane_q, lane_d;
    logic [CNT_W-1:0]                         rem_q, rem_d;
    logic                                     done_q, done_d;
    logic                                     err_q, err_d;
    logic                                     beat_rdy, elem_hs, beat_hs, last_elem;

    assign last_elem = (rem_q == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        lane_d     = lane_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        beat_rdy   = 1'b0;
        elem_hs    = 1'b0;
        beat_hs    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_elems_i != '0) begin
                        rem_d   = num_elems_i;
                        lane_d  = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Refill on the final-lane handshake so the next beat follows with no bubble.
                beat_rdy = !buf_full_q || (rdy_i && lane_q == LAST_LANE && !last_elem);
                elem_hs  = buf_full_q && rdy_i;
                beat_hs  = beat_vld_i && beat_rdy;
                if (elem_hs && last_elem) begin
                    buf_full_d = 1'b0;
                    lane_d     = '0;
                    rem_d      = '0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    if (elem_hs) begin
                        rem_d  = rem_q - CNT_W'(1);
                        lane_d = lane_q + LANE_W'(1);
                        if (lane_q == LAST_LANE) buf_full_d = 1'b0;
                    end
                    if (beat_hs) begin
                        buf_d      = beat_data_i;
                        buf_full_d = 1'b1;
                        lane_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            lane_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            lane_q     <= lane_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign beat_rdy_o = beat_rdy;
    assign data_o     = buf_q[lane_q];
    assign vld_o      = buf_full_q;
    assign last_o     = buf_full_q && last_elem;
    assign idle_o     = (state_q == IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_ebpc_input_unpacker.sv
// Bench for the input unpacker: table of stream scenarios checked against a queue-based model.
module tb_ebpc_input_unpacker;

    localparam int W     = 4;
    localparam int CNT_W = 24;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [CNT_W-1:0] num_elems_i;
    logic [8*W-1:0]   beat_data_i;
    logic             beat_vld_i;
    logic             beat_rdy_o;
    logic [7:0]       data_o;
    logic             last_o;
    logic             vld_o;
    logic             rdy_i;
    logic             idle_o;
    logic             done_o;
    logic             err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    ebpc_input_unpacker #(.WORDS_PER_BEAT(W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .num_elems_i(num_elems_i),
        .beat_data_i(beat_data_i), .beat_vld_i(beat_vld_i), .beat_rdy_o(beat_rdy_o),
        .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .idle_o(idle_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " beat_rdy"}, beat_rdy_o, 0);
        chk({tag, " vld"},      vld_o,      0);
        chk({tag, " last"},     last_o,     0);
        chk({tag, " data"},     data_o,     0);
        chk({tag, " done"},     done_o,     0);
        chk({tag, " err"},      err_o,      0);
        chk({tag, " idle"},     idle_o,     1);
    endtask

    typedef struct {
        int n;          // stream length
        int rdy_pct;    // chance downstream is ready each cycle
        int gap;        // cycles beat_vld_i is withheld while the unpacker wants a beat
        bit rnd;        // random beat payload instead of 01,02,03...
        bit mid_start;  // pulse start_i during RUN
        int abort_at;   // assert reset after this many elements (0 = never)
        int exp_beats;  // beat handshakes expected
        int exp_bub;    // vld_o-low cycles inside the stream (-1 = unchecked)
    } vec_t;

    // Runs one stream; the model is simply "the first n bytes of the offered beats, in order".
    task automatic run_stream(input vec_t v);
        logic [31:0] bq[$];
        logic [7:0]  exp_q[$];
        int nb, bi, idx, beats_acc, gap_cnt, bubbles, cyc, done_st;
        bit first_vld, pstall, beat_acc_prev, ehs, bhs;
        logic [7:0] pdata;
        logic       plast;
        logic [31:0] w;

        nb = (v.n + W - 1) / W + 1;
        for (int b = 0; b < nb; b++) begin
            if (v.rnd) w = $urandom;
            else       w = {8'(b*4+4), 8'(b*4+3), 8'(b*4+2), 8'(b*4+1)};
            bq.push_back(w);
            for (int l = 0; l < W; l++)
                if (exp_q.size() < v.n) exp_q.push_back(w[l*8 +: 8]);
        end

        @(negedge clk_i);
        start_i = 1'b1; num_elems_i = CNT_W'(v.n);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("run idle_o", idle_o, 0);

        bi = 0; idx = 0; beats_acc = 0; gap_cnt = 0; bubbles = 0; cyc = 0; done_st = 0;
        first_vld = 0; pstall = 0; beat_acc_prev = 0; pdata = 0; plast = 0;

        while (cyc < 2000) begin
            cyc++;
            if (v.abort_at > 0 && idx == v.abort_at) begin
                rst_i = 1'b1;
                #1;
                chk_reset_outputs("midrst");
                chk("midrst idle", idle_o, 1);
                beat_vld_i = 1'b0; rdy_i = 1'b0;
                #1 rst_i = 1'b0;
                return;
            end
            if (pstall) begin
                chk("stall vld", vld_o, 1);
                chk("stall data", data_o, pdata);
                chk("stall last", last_o, plast);
            end
            if (done_st == 1) begin
                chk("done pulse", done_o, 1);
                done_st = 2;
            end else if (done_st == 2) begin
                chk("done width", done_o, 0);
                break;
            end else if (done_o) begin
                chk("early done", done_o, 0);
            end
            if (vld_o) first_vld = 1;
            else if (first_vld && idx < v.n) bubbles++;

            if (beat_acc_prev) begin
                beat_vld_i = 1'b0;
                gap_cnt = (bi < nb) ? v.gap : 0;
                if (beats_acc == 0) gap_cnt = 0;
            end
            start_i = (v.mid_start && cyc == 4);
            num_elems_i = v.mid_start && cyc == 4 ? CNT_W'(3) : CNT_W'(v.n);
            rdy_i = ($urandom_range(99) < v.rdy_pct);
            #1;
            if (!beat_vld_i && bi < nb) begin
                if (gap_cnt == 0) begin
                    beat_vld_i = 1'b1; beat_data_i = bq[bi];
                end else if (beat_rdy_o) begin
                    gap_cnt--;
                end
            end
            #1;
            ehs = vld_o && rdy_i;
            bhs = beat_vld_i && beat_rdy_o;
            if (ehs) begin
                if (idx < v.n) begin
                    chk($sformatf("elem%0d data", idx), data_o, exp_q[idx]);
                    chk($sformatf("elem%0d last", idx), last_o, (idx == v.n - 1));
                end else begin
                    chk("extra elem", idx, v.n);
                end
                idx++;
                if (idx == v.n) done_st = 1;
            end
            if (bhs) begin bi++; beats_acc++; end
            beat_acc_prev = bhs;
            pstall = vld_o && !rdy_i;
            pdata = data_o; plast = last_o;
            @(negedge clk_i);
        end
        chk("stream timeout", (cyc < 2000), 1);
        start_i = 1'b0;
        chk("end idle", idle_o, 1);
        chk("end beat_rdy", beat_rdy_o, 0);
        chk("elem count", idx, v.n);
        chk("beat count", beats_acc, v.exp_beats);
        if (v.exp_bub >= 0) chk("bubbles", bubbles, v.exp_bub);
        beat_vld_i = 1'b0; rdy_i = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; num_elems_i = '0; beat_data_i = '0;
        beat_vld_i = 1'b0; rdy_i = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_reset_outputs("post-reset");

        // zero-length start: error pulse, stays idle, no beat requested
        beat_vld_i = 1'b1; beat_data_i = 32'h11223344;
        start_i = 1'b1; num_elems_i = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("err pulse", err_o, 1);
        chk("err idle", idle_o, 1);
        chk("err beat_rdy", beat_rdy_o, 0);
        @(negedge clk_i);
        chk("err width", err_o, 0);
        chk("err still idle", idle_o, 1);
        beat_vld_i = 1'b0;

        //          n  rdy gap rnd mid abort beats bub
        vecs.push_back('{8, 100, 0, 0, 0, 0, 2, 0});
        vecs.push_back('{5, 100, 0, 0, 0, 0, 2, 0});
        vecs.push_back('{6,  50, 0, 1, 0, 0, 2, -1});
        vecs.push_back('{8, 100, 3, 0, 0, 0, 2, 3});
        vecs.push_back('{8, 100, 0, 1, 1, 0, 2, 0});
        vecs.push_back('{1, 100, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{4, 100, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{13, 70, 2, 1, 0, 0, 4, -1});
        vecs.push_back('{8, 100, 0, 0, 0, 3, 0, -1});
        vecs.push_back('{4, 100, 0, 0, 0, 0, 1, 0});
        for (int i = 0; i < vecs.size(); i++) run_stream(vecs[i]);

        // randomized lengths, stalls and gaps
        for (int i = 0; i < 12; i++) begin
            rv.n = $urandom_range(1, 23);
            rv.rdy_pct = $urandom_range(30, 100);
            rv.gap = $urandom_range(0, 3);
            rv.rnd = 1; rv.mid_start = $urandom_range(0, 1); rv.abort_at = 0;
            rv.exp_beats = (rv.n + W - 1) / W;
            rv.exp_bub = -1;
            run_stream(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ebpc_input_unpacker.md
Name: ebpc_input_unpacker

Overview:
- Upstream feeder of the EBPC encoder.
- Accepts wide input beats of WORDS_PER_BEAT packed DATA_W-bit activations, for example from a DMA/AXI-stream port.
- Serialises them into one DATA_W element per cycle with a valid/ready handshake.
- Asserts last on the final element of a programmed-length stream. The encoder's data/last/valid/ready inputs connect directly to this block's element outputs.

Parameters:
- DATA_W, 8, element width. Equals the encoder data width and comes from the shared package.
- WORDS_PER_BEAT, 4, elements per input beat. Must be ≥2 and a power of two.
- CNT_W, 24, width of the element-count register. Maximum stream length is 2^CNT_W-1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  start pulse. Sampled only in IDLE.
- num_elems_i  in  CNT_W  total elements in the stream. Latched on start_i.
- beat_data_i  in  DATA_W*WORDS_PER_BEAT  packed input beat. Lane 0 occupies bits [DATA_W-1:0].
- beat_vld_i  in  1  input beat valid.
- beat_rdy_o  out  1  input beat ready.
- data_o  out  DATA_W  serial element.
- last_o  out  1  final element of the stream. Qualified by vld_o.
- vld_o  out  1  element valid.
- rdy_i  in  1  element ready from downstream.
- idle_o  out  1  high in IDLE.
- done_o  out  1  one-cycle pulse after the last element handshake.
- err_o  out  1  one-cycle pulse when start_i arrives with num_elems_i==0.

Behaviour:
- Reset values: beat_rdy_o=0, vld_o=0, last_o=0, data_o=0, done_o=0, err_o=0, idle_o=1. All internal registers are cleared and the state is IDLE. Reset mid-stream discards any buffered beat and the count; no done_o is issued.
- Handshakes: a transfer occurs when valid&&ready are high on a rising edge.
  - vld_o never depends combinationally on rdy_i.
  - Once vld_o is asserted, data_o and last_o hold stable until the handshake.
  - beat_rdy_o may depend combinationally on rdy_i.
- State IDLE:
  - beat_rdy_o=0, vld_o=0.
  - start_i with num_elems_i>0: latch remaining=num_elems_i, lane=0, go to RUN.
  - start_i with num_elems_i==0: pulse err_o next cycle, stay in IDLE.
- State RUN: holds a one-beat buffer with a buf_full flag and a lane index of width $clog2(WORDS_PER_BEAT).
  - data_o = buffer lane `lane`.
  - vld_o = buf_full.
  - last_o = buf_full && remaining==1.
- Element handshake:
  - remaining decrements and lane increments, wrapping from WORDS_PER_BEAT-1 to 0.
  - When lane wraps, buf_full clears unless a new beat is accepted in the same cycle.
- beat_rdy_o = !buf_full || (rdy_i && lane==WORDS_PER_BEAT-1 && remaining!=1). This allows back-to-back beats with no bubble: sustained throughput is one element per cycle.
- Latency: the first element is valid the cycle after the beat handshake. No combinational path from beat_data_i to data_o.
- Simultaneous events: a beat accepted in the same cycle as the final-lane element handshake loads the buffer, sets lane=0 and keeps buf_full=1.
- Last element handshake:
  - Any unconsumed lanes of the current beat are discarded. No further beat is requested.
  - buf_full clears, done_o pulses the following cycle, state returns to IDLE.
  - A stream length that is not a multiple of WORDS_PER_BEAT therefore consumes ceil(n/WORDS_PER_BEAT) beats.
- Upstream stall: if beat_vld_i is low when the buffer empties, vld_o drops. There are no bubbles otherwise.
- start_i is ignored in RUN.
- remaining is never decremented below 1 except on the last handshake, so no underflow is possible.

Decomposition:
- Shared package (ebpc_pkg): DATA_W. Add constant WORDS_PER_BEAT_DEFAULT and the typedef unpacker_state_t {IDLE, RUN}.
- No sub-module. Beat buffer, lane counter and element counter live in one always_comb/always_ff pair.

Test Plan:
- Length 8, WORDS_PER_BEAT=4, rdy_i tied 1, beats 0x04030201 then 0x08070605 offered back-to-back → data_o 01..08 on 8 consecutive cycles, last_o only with 08, done_o one cycle later, idle_o=1 after.
- Length 5, beats 0x04030201 and 0xDDCCBB05 → data_o 01..05, last_o with 05. The second beat's lanes 1..3 are dropped. Exactly 2 beat handshakes, and beat_rdy_o=0 afterwards.
- Length 6, rdy_i random 50% → data_o/last_o stable whenever vld_o=1 && rdy_i=0. Output sequence and last position match the unstalled run.
- beat_vld_i withheld 3 cycles between beats of a length-8 stream → vld_o low for exactly those cycles. No duplicated or lost elements.
- start_i with num_elems_i=0 → err_o pulse, state stays IDLE, beat_rdy_o stays 0. start_i pulsed mid-RUN → ignored.
- rst_i asserted after 3 elements of a length-8 stream → all outputs at reset values immediately. A subsequent length-4 stream runs cleanly with the correct last_o.
